ysyx_23060187_mem_arbiter: RTL
==============================

YSYX_23060187_MEM_ARBITER -- requirements
Module: ysyx_23060187_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles waited for a memory response before an error response is returned (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low: rst=0 resets.
REQ-004 ifu_valid  input  1  instruction-fetch request valid.
REQ-005 ifu_ready  output  1  fetch request accepted this cycle.
REQ-006 ifu_addr  input  32  fetch address.
REQ-007 ifu_rvalid  output  1  one-cycle fetch response pulse.
REQ-008 ifu_rdata  output  32  fetch data, valid with ifu_rvalid.
REQ-009 ifu_err  output  1  fetch timed out, valid with ifu_rvalid.
REQ-010 lsu_valid / lsu_ready  input / output  1 / 1  load-store request handshake.
REQ-011 lsu_addr, lsu_wdata  input  32 each  load-store address and store data.
REQ-012 lsu_wen  input  1  1 = store, 0 = load.
REQ-013 lsu_wmask  input  4  store byte enables.
REQ-014 lsu_rvalid, lsu_rdata, lsu_err  output  1/32/1  load-store response, same rules as IFU.
REQ-015 mem_valid / mem_ready  output / input  1 / 1  downstream request handshake.
REQ-016 mem_addr, mem_wdata  output  32 each; mem_wen  output  1; mem_wmask  output  4.
REQ-017 mem_rvalid  input  1; mem_rdata  input  32  downstream response, at least one cycle after the mem_valid&mem_ready cycle.

Function
REQ-018 FSM states IDLE, REQ, WAIT, RESP; one outstanding transaction at a time.
REQ-019 IDLE: on any request valid, select the winner, assert only the winner's ready combinationally in that cycle, latch its addr/wen/wdata/wmask and owner, go to REQ.
REQ-020 Selection: only one valid -> that one; both valid -> the requester not granted last time; the first contention after reset goes to LSU.
REQ-021 IFU transactions drive mem_wen=0, mem_wmask=4'b0000, mem_wdata=0.
REQ-022 REQ: mem_valid=1 with latched fields held stable; on mem_ready=1 go to WAIT and clear the timeout counter.
REQ-023 WAIT: counter increments each cycle; mem_rvalid=1 -> latch mem_rdata, err=0, go to RESP; counter reaches TIMEOUT with no mem_rvalid -> rdata=0, err=1, go to RESP.
REQ-024 RESP: owner's rvalid=1 for exactly one cycle with latched rdata/err; the other port's rvalid=0; next state IDLE.
REQ-025 Store responses are pulsed identically to loads; rdata is whatever mem_rdata returned.
REQ-026 ifu_ready/lsu_ready are 0 in REQ, WAIT and RESP; a request held valid there waits without loss.
REQ-027 mem_rvalid outside WAIT is ignored; mem_rvalid in the timeout cycle is taken as a valid response (err=0).
REQ-028 Minimum latency: accept at cycle N, mem_ready at N+1, mem_rvalid at N+2 -> rvalid at N+3; next accept at N+4.
REQ-029 Outputs rdata/err hold their last value outside RESP; only rvalid qualifies them.

Reset
REQ-030 rst=0 forces IDLE immediately, asynchronously: mem_valid, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err = 0; rdata outputs = 0; counter = 0; last-grant = IFU (so LSU wins first contention).
REQ-031 Reset mid-transaction drops it silently; no response is ever pulsed for it.

Structure
REQ-032 Shared package ysyx_23060187_pkg holds the FSM state encoding, the owner encoding (OWN_IFU, OWN_LSU) and the TIMEOUT default.
REQ-033 One sub-module ysyx_23060187_rr_arb2: 2-way round-robin pick with last-grant register, grant-enable input, one-hot grant output.

Verification
REQ-034 IFU only, addr 0x8000_0000, mem_ready=1 immediately, mem_rvalid next cycle, rdata 0x0000_0413 -> ifu_rvalid at accept+3, ifu_rdata 0x0000_0413, ifu_err=0.
REQ-035 Both valid in the same IDLE cycle after reset -> LSU granted first, IFU second; repeat contention -> IFU, LSU alternate.
REQ-036 LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b1111 -> mem_wen=1, fields stable while mem_ready held 0 for 5 cycles, lsu_rvalid after response.
REQ-037 TIMEOUT=4, mem_rvalid never asserted -> lsu_rvalid with lsu_rdata 0, lsu_err=1 exactly 4 WAIT cycles after mem_ready, then IDLE.
REQ-038 rst=0 during WAIT, then late mem_rvalid after release -> no rvalid pulse on either port, mem_valid=0, next request served normally.

Source files
------------

// File: rtl/ysyx_23060187_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner ids,
// the latched request bundle and the default response timeout.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_DEF = 255;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
    } mem_req_t;

endpackage

// File: rtl/ysyx_23060187_rr_arb2.sv
// Two-way round-robin picker; index 0 is the IFU, index 1 the LSU.
// The last-grant register resets to IFU so the LSU wins the first tie.
module ysyx_23060187_rr_arb2
    import ysyx_23060187_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    owner_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            if (req_i[1] && (!req_i[0] || last_q == OWN_IFU)) begin
                gnt_o = 2'b10;
            end else if (req_i[0]) begin
                gnt_o = 2'b01;
            end
        end
        if (gnt_o[1]) begin
            last_d = OWN_LSU;
        end else if (gnt_o[0]) begin
            last_d = OWN_IFU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_IFU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ysyx_23060187_mem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto a single memory port,
// one outstanding transaction at a time, with a response timeout.
module ysyx_23060187_mem_arbiter
    import ysyx_23060187_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    output logic        ifu_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic        lsu_wen,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    mem_req_t    req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        ifu_err_q, ifu_err_d;
    logic        lsu_err_q, lsu_err_d;
    logic [1:0]  gnt;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_done;

    ysyx_23060187_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == ST_IDLE),
        .req_i ({lsu_valid, ifu_valid}),
        .gnt_o (gnt)
    );

    assign ifu_ready = gnt[0];
    assign lsu_ready = gnt[1];

    // A response in the final wait cycle still beats the timeout.
    always_comb begin
        resp_done = 1'b0;
        resp_data = '0;
        resp_err  = 1'b0;
        if (mem_rvalid) begin
            resp_done = 1'b1;
            resp_data = mem_rdata;
        end else if (cnt_q + 8'd1 == TO_LAST) begin
            resp_done = 1'b1;
            resp_err  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_err_d   = ifu_err_q;
        lsu_err_d   = lsu_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt[1]) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_LSU;
                    req_d.addr  = lsu_addr;
                    req_d.wdata = lsu_wdata;
                    req_d.wmask = lsu_wmask;
                    req_d.wen   = lsu_wen;
                end else if (gnt[0]) begin
                    state_d     = ST_REQ;
                    owner_d     = OWN_IFU;
                    req_d.addr  = ifu_addr;
                    req_d.wdata = '0;
                    req_d.wmask = '0;
                    req_d.wen   = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (resp_done) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_LSU) begin
                        lsu_rdata_d = resp_data;
                        lsu_err_d   = resp_err;
                    end else begin
                        ifu_rdata_d = resp_data;
                        ifu_err_d   = resp_err;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IFU;
            req_q       <= '0;
            cnt_q       <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign mem_valid  = (state_q == ST_REQ);
    assign mem_addr   = req_q.addr;
    assign mem_wdata  = req_q.wdata;
    assign mem_wmask  = req_q.wmask;
    assign mem_wen    = req_q.wen;

    assign ifu_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_rvalid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata  = ifu_rdata_q;
    assign lsu_rdata  = lsu_rdata_q;
    assign ifu_err    = ifu_err_q;
    assign lsu_err    = lsu_err_q;

endmodule
